led_pwm_gen: RTL and testbench
==============================

// Module: led_pwm_gen
// PURPOSE
// - Downstream stage of the 4-bit brightness counter: consumes its count as duty_in and drives the LED.
// - Produces a glitch-free PWM waveform whose duty is latched only at period boundaries.
// - Optional fade mode slews the applied duty by one step per period toward the requested value.
// PARAMETERS
// - DUTY_W    4  duty/phase width; PERIOD = 2**DUTY_W - 1 ticks (15 at default)
// - PRESCALE  4  pwm_clk cycles per phase tick; legal range >= 1
// - FADE_EN   0  0: applied duty jumps to duty_in at a wrap; 1: moves +/-1 per wrap
// PORTS
// - pwm_clk       in   1       single clock; all state on rising edge
// - reset_n       in   1       asynchronous, active-low reset
// - duty_in       in   DUTY_W  requested duty, 0 = off, PERIOD = always on; sampled only at wrap
// - enable        in   1       0 forces pwm_out low; counters keep running
// - pwm_out       out  1       registered PWM output to LED
// - period_start  out  1       registered one-cycle pulse, first cycle of each period
// - duty_applied  out  DUTY_W  duty currently in effect (shadow register)
// BEHAVIOUR
// - Reset (async, reset_n=0): presc_cnt, phase, duty_applied, pwm_out and period_start all 0, immediately.
// - Reset release: first tick occurs PRESCALE cycles after the first active edge.
// - Prescaler:
//   - presc_cnt counts 0..PRESCALE-1.
//   - tick = (presc_cnt == PRESCALE-1), combinational; presc_cnt returns to 0 on tick.
//   - PRESCALE=1: tick is high every cycle and presc_cnt stays 0.
// - Phase:
//   - On tick, phase increments 0..PERIOD-1, then wraps to 0.
//   - wrap = tick & (phase == PERIOD-1).
// - Shadow duty, updated on wrap only:
//   - FADE_EN=0: duty_applied <= duty_in.
//   - FADE_EN=1: +1 if duty_in > duty_applied, -1 if less, hold if equal. No overshoot; width never exceeded.
//   - duty_in changes between wraps have no effect on the current period.
// - period_start <= wrap: high exactly 1 cycle, the cycle phase first reads 0.
// - pwm_out <= enable & (phase < duty_applied):
//   - One cycle of latency from the register values.
//   - duty 0: never high. duty PERIOD: constantly high.
//   - High time per period = duty_applied * PRESCALE cycles; period = PERIOD * PRESCALE cycles.
// - enable:
//   - Deassert: pwm_out=0 on the next edge. Phase and duty continue, so re-enable resumes in phase.
//   - Mid-period assert: output follows the comparison from the next edge; no partial-period suppression.
// - Simultaneous wrap and duty_in change: the value present on the wrap cycle is the one sampled.
// - Reset mid-period: output drops low asynchronously; restarts at phase 0 with duty_applied=0.
//   - Consequence: the first full period after reset is always dark.
// - No combinational path from any input to any output.
// TESTING (DUTY_W=4, PRESCALE=4 unless noted; period = 60 cycles)
// - Static duty: duty_in=5, FADE_EN=0 -> from 2nd period, pwm_out high 20 of every 60 cycles; period_start every 60.
// - Extremes: duty_in=0 -> pwm_out always 0.
//   - duty_in=15 -> pwm_out stays 1 across wraps, no 1-cycle low glitch.
// - Mid-period change: duty 3 -> 12 at phase 6 -> current period keeps 12 high cycles; next period 48.
// - Fade (FADE_EN=1): duty_in 0 -> 15 -> duty_applied 1,2,...,15 on 15 successive wraps.
//   - Then duty_in=10 -> decrements one per wrap to 10 and holds.
// - Enable/reset: enable=0 for 100 cycles -> pwm_out 0 while period_start keeps its 60-cycle cadence.
//   - reset_n pulse at phase 9 -> all outputs 0 immediately; first tick 4 cycles after release.
// - PRESCALE=1, duty_in=7 -> pwm_out high 7 of 15 cycles.

Source files
------------

// File: rtl/led_pwm_gen.sv
// LED PWM generator: prescaled phase counter compared against a shadow duty register.
// Latency: pwm_out/period_start are registered, one cycle behind the phase/duty registers.
// Backpressure: none; free-running stream, duty_in sampled only on the period wrap cycle.
//
// Ports:
//   pwm_clk       single clock, all state on rising edge
//   reset_n       asynchronous active-low reset
//   duty_in       requested duty (0 = off, PERIOD = always on), sampled at wrap
//   enable        0 forces pwm_out low while counters keep running
//   pwm_out       registered PWM output
//   period_start  registered one-cycle pulse on the first cycle of each period
//   duty_applied  duty currently in effect (shadow register)
module led_pwm_gen #(
    parameter int DUTY_W   = 4,
    parameter int PRESCALE = 4,
    parameter bit FADE_EN  = 1'b0
) (
    input  logic              pwm_clk,
    input  logic              reset_n,
    input  logic [DUTY_W-1:0] duty_in,
    input  logic              enable,
    output logic              pwm_out,
    output logic              period_start,
    output logic [DUTY_W-1:0] duty_applied
);

    localparam int PERIOD = (1 << DUTY_W) - 1;
    // Keep the prescaler at least one bit wide so PRESCALE=1 still elaborates.
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]     PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [DUTY_W-1:0] PHASE_LAST = DUTY_W'(PERIOD - 1);

    logic [PW-1:0]     presc_cnt;
    logic [DUTY_W-1:0] phase;
    logic [DUTY_W-1:0] duty_next;
    logic              tick;
    logic              wrap;

    assign tick = (presc_cnt == PRESC_LAST);
    assign wrap = tick && (phase == PHASE_LAST);

    // Value loaded into the shadow register at the next wrap. In fade mode the
    // step is a single count toward duty_in, so it can neither overshoot nor
    // leave the DUTY_W range.
    always_comb begin
        duty_next = duty_in;
        if (FADE_EN) begin
            duty_next = duty_applied;
            if (duty_in > duty_applied) begin
                duty_next = duty_applied + DUTY_W'(1);
            end else if (duty_in < duty_applied) begin
                duty_next = duty_applied - DUTY_W'(1);
            end
        end
    end

    always_ff @(posedge pwm_clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_cnt    <= '0;
            phase        <= '0;
            duty_applied <= '0;
            pwm_out      <= 1'b0;
            period_start <= 1'b0;
        end else begin
            // With PRESCALE=1 tick is permanently high and presc_cnt stays 0.
            presc_cnt <= tick ? '0 : presc_cnt + PW'(1);

            if (tick) begin
                phase <= (phase == PHASE_LAST) ? '0 : phase + DUTY_W'(1);
            end

            if (wrap) begin
                duty_applied <= duty_next;
            end

            period_start <= wrap;
            // Compares the current (pre-update) phase and duty; on a wrap the
            // old duty still governs the last phase of the ending period.
            pwm_out      <= enable && (phase < duty_applied);
        end
    end

endmodule

// File: tb/tb_led_pwm_gen.sv
// Testbench for led_pwm_gen: three instances (prescale 4 jump, prescale 4 fade,
// prescale 1 jump) share stimulus. A time-based reference model pushes one
// expected record per period into a queue; a monitor pops on every period_start.
module tb_led_pwm_gen;

    typedef struct packed {
        int dapp;
        int hi;
        int len;
    } rec_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] duty_in;
    logic       enable;
    logic [2:0] po;
    logic [2:0] ps;
    logic [3:0] da [3];

    int checks = 0;
    int failures = 0;

    // Reference model state: n = rising edges since reset release.
    int presc_of [3] = '{4, 4, 1};
    bit fade_of  [3] = '{1'b0, 1'b1, 1'b0};
    int n;
    int m_dapp [3];
    int m_hi   [3];
    int m_len  [3];
    rec_t q0[$];
    rec_t q1[$];
    rec_t q2[$];

    // Monitor state
    int   o_hi  [3];
    int   o_len [3];
    rec_t mr;
    bit   mok;

    always #5 clk = ~clk;

    led_pwm_gen #(.DUTY_W(4), .PRESCALE(4), .FADE_EN(1'b0)) u_a (
        .pwm_clk(clk), .reset_n(reset_n), .duty_in(duty_in), .enable(enable),
        .pwm_out(po[0]), .period_start(ps[0]), .duty_applied(da[0])
    );

    led_pwm_gen #(.DUTY_W(4), .PRESCALE(4), .FADE_EN(1'b1)) u_b (
        .pwm_clk(clk), .reset_n(reset_n), .duty_in(duty_in), .enable(enable),
        .pwm_out(po[1]), .period_start(ps[1]), .duty_applied(da[1])
    );

    led_pwm_gen #(.DUTY_W(4), .PRESCALE(1), .FADE_EN(1'b0)) u_c (
        .pwm_clk(clk), .reset_n(reset_n), .duty_in(duty_in), .enable(enable),
        .pwm_out(po[2]), .period_start(ps[2]), .duty_applied(da[2])
    );

    task automatic chk(input string nm, input int i, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s inst%0d: got %0d expected %0d at %0t", nm, i, got, exp, $time);
        end
    endtask

    task automatic push_rec(input int i, input rec_t r);
        case (i)
            0: q0.push_back(r);
            1: q1.push_back(r);
            default: q2.push_back(r);
        endcase
    endtask

    task automatic pop_rec(input int i, output bit ok, output rec_t r);
        ok = 1'b0;
        r  = '0;
        case (i)
            0: if (q0.size() > 0) begin r = q0.pop_front(); ok = 1'b1; end
            1: if (q1.size() > 0) begin r = q1.pop_front(); ok = 1'b1; end
            default: if (q2.size() > 0) begin r = q2.pop_front(); ok = 1'b1; end
        endcase
    endtask

    function automatic int qsize(input int i);
        case (i)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    // One clock of stimulus, called at a falling edge. Drives inputs, then
    // predicts what the following rising edge produces for every instance.
    task automatic step(input logic [3:0] d, input logic e);
        int ph;
        int ex;
        rec_t r;
        duty_in = d;
        enable  = e;
        for (int i = 0; i < 3; i++) begin
            ph = (n / presc_of[i]) % 15;
            ex = (e && (ph < m_dapp[i])) ? 1 : 0;
            if (((n + 1) % (15 * presc_of[i])) == 0) begin
                if (!fade_of[i]) begin
                    m_dapp[i] = int'(d);
                end else if (int'(d) > m_dapp[i]) begin
                    m_dapp[i] = m_dapp[i] + 1;
                end else if (int'(d) < m_dapp[i]) begin
                    m_dapp[i] = m_dapp[i] - 1;
                end
                r.dapp = m_dapp[i];
                r.hi   = m_hi[i];
                r.len  = m_len[i];
                push_rec(i, r);
                m_hi[i]  = 0;
                m_len[i] = 0;
            end
            m_hi[i]  = m_hi[i] + ex;
            m_len[i] = m_len[i] + 1;
        end
        n = n + 1;
        @(negedge clk);
    endtask

    // Called at a falling edge; returns at a falling edge with reset released.
    task automatic do_reset(input int hold);
        reset_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("reset_pwm_out", i, int'(po[i]), 0);
            chk("reset_period_start", i, int'(ps[i]), 0);
            chk("reset_duty_applied", i, int'(da[i]), 0);
            m_dapp[i] = 0;
            m_hi[i]   = 0;
            m_len[i]  = 0;
        end
        q0.delete();
        q1.delete();
        q2.delete();
        n = 0;
        repeat (hold) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Monitor: one sample per cycle; a period_start closes the previous window.
    always @(posedge clk) begin
        #1;
        if (!reset_n) begin
            for (int i = 0; i < 3; i++) begin
                o_hi[i]  = 0;
                o_len[i] = 0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (ps[i]) begin
                    pop_rec(i, mok, mr);
                    chk("period_start_expected", i, int'(mok), 1);
                    if (mok) begin
                        chk("duty_applied", i, int'(da[i]), mr.dapp);
                        chk("high_cycles", i, o_hi[i], mr.hi);
                        chk("window_len", i, o_len[i], mr.len);
                    end
                    o_hi[i]  = 0;
                    o_len[i] = 0;
                end
                o_hi[i]  = o_hi[i] + int'(po[i]);
                o_len[i] = o_len[i] + 1;
            end
        end
    end

    initial begin
        logic [3:0] d;
        logic       e;
        reset_n = 1'b0;
        duty_in = 4'd0;
        enable  = 1'b0;
        n = 0;
        for (int i = 0; i < 3; i++) begin
            m_dapp[i] = 0; m_hi[i] = 0; m_len[i] = 0;
            o_hi[i] = 0; o_len[i] = 0;
        end
        @(negedge clk);
        do_reset(3);

        // Static duty, then extremes
        repeat (180) step(4'd5, 1'b1);
        repeat (120) step(4'd0, 1'b1);
        repeat (180) step(4'd15, 1'b1);
        // Duty 3 then change mid-period to 12
        repeat (84) step(4'd3, 1'b1);
        repeat (120) step(4'd12, 1'b1);
        // PRESCALE=1 instance at duty 7
        repeat (45) step(4'd7, 1'b1);
        // Enable low for 100 cycles, counters keep running
        repeat (100) step(4'd8, 1'b0);
        repeat (120) step(4'd8, 1'b1);
        // Fade ramps: down to 0, up to 15, then back to 10
        repeat (600) step(4'd0, 1'b1);
        repeat (960) step(4'd15, 1'b1);
        repeat (420) step(4'd10, 1'b1);

        // Reset while instance 0 sits at phase 9 with its output high
        while (((n / 4) % 15) != 9) step(4'd10, 1'b1);
        do_reset(2);
        repeat (130) step(4'd10, 1'b1);

        // Randomized stretch
        d = 4'($urandom_range(0, 15));
        e = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 19) == 0) d = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 59) == 0) e = ~e;
            step(d, e);
        end

        // Every predicted period must have been observed
        @(posedge clk);
        #3;
        for (int i = 0; i < 3; i++) begin
            chk("unconsumed_periods", i, qsize(i), 0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
